// File: rtl/compmac.sv
// rtl/compmac.sv - pipelined complex multiply-accumulate with per-frame sum output
//
// Purpose: multiplies A by B (or by conj(B)) once per accepted sample. It sums
// a programmable number of products (len, where 0 means 1) and presents one
// full-precision complex sum per frame.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   in_valid           operands and conj are valid this cycle
//   a_r, a_i, b_r, b_i signed N-bit operand components
//   conj               1: multiply by conj(B) for this sample
//   len                products per frame, latched on the first sample
//   out_valid          one-cycle pulse when c_r/c_i carry a new frame sum
//   c_r, c_i           signed ACC_W-bit frame sum, held between pulses
module compmac #(
  parameter int N     = 8,
  parameter int LEN_W = 8,
  parameter int ACC_W = 2*N+1+LEN_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [N-1:0]     a_r,
  input  logic signed [N-1:0]     a_i,
  input  logic signed [N-1:0]     b_r,
  input  logic signed [N-1:0]     b_i,
  input  logic                    conj,
  input  logic [LEN_W-1:0]        len,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] c_r,
  output logic signed [ACC_W-1:0] c_i
);

  localparam int PW = 2*N;
  localparam int SW = 2*N+1;

  // Frame counter and length latch
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, len_eff, len_m1;
  logic             first_smp, last_in;

  always_comb begin
    first_smp = (cnt_q == '0);
    // The first sample of a frame sees len directly, because len_q is only
    // loaded at that same edge.
    len_eff   = first_smp ? len : len_q;
    len_m1    = (len_eff == '0) ? '0 : len_eff - LEN_W'(1);
    last_in   = (cnt_q == len_m1);
    cnt_d     = cnt_q;
    len_d     = len_q;
    if (in_valid) begin
      if (first_smp) len_d = len;
      cnt_d = last_in ? '0 : cnt_q + LEN_W'(1);
    end
  end

  // Operands sign-extended to product width so each multiply is full precision
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  assign ar_x = PW'(a_r);
  assign ai_x = PW'(a_i);
  assign br_x = PW'(b_r);
  assign bi_x = PW'(b_i);

  // S1: four partial products
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic                 v1_q, last1_q, conj1_q;

  // S2: real/imag sum or difference. b_i is never negated; conjugation
  // only swaps which terms are added or subtracted.
  logic signed [SW-1:0] re2_d, im2_d, re2_q, im2_q;
  logic                 v2_q, last2_q;

  always_comb begin
    if (conj1_q) begin
      re2_d = SW'(p_rr_q) + SW'(p_ii_q);
      im2_d = SW'(p_ir_q) - SW'(p_ri_q);
    end else begin
      re2_d = SW'(p_rr_q) - SW'(p_ii_q);
      im2_d = SW'(p_ri_q) + SW'(p_ir_q);
    end
  end

  // S3: accumulate
  logic signed [ACC_W-1:0] acc_r_q, acc_i_q, sum_r_d, sum_i_d;
  assign sum_r_d = acc_r_q + ACC_W'(re2_q);
  assign sum_i_d = acc_i_q + ACC_W'(im2_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      len_q     <= '0;
      p_rr_q    <= '0;
      p_ii_q    <= '0;
      p_ri_q    <= '0;
      p_ir_q    <= '0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      conj1_q   <= 1'b0;
      re2_q     <= '0;
      im2_q     <= '0;
      v2_q      <= 1'b0;
      last2_q   <= 1'b0;
      acc_r_q   <= '0;
      acc_i_q   <= '0;
      c_r       <= '0;
      c_i       <= '0;
      out_valid <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;

      v1_q    <= in_valid;
      last1_q <= in_valid & last_in;
      if (in_valid) begin
        p_rr_q  <= ar_x * br_x;
        p_ii_q  <= ai_x * bi_x;
        p_ri_q  <= ar_x * bi_x;
        p_ir_q  <= ai_x * br_x;
        conj1_q <= conj;
      end

      v2_q    <= v1_q;
      last2_q <= last1_q;
      if (v1_q) begin
        re2_q <= re2_d;
        im2_q <= im2_d;
      end

      out_valid <= 1'b0;
      if (v2_q) begin
        if (last2_q) begin
          // Close the frame: publish and clear together, so a new frame's
          // first product lands on a zero accumulator with no gap.
          c_r       <= sum_r_d;
          c_i       <= sum_i_d;
          out_valid <= 1'b1;
          acc_r_q   <= '0;
          acc_i_q   <= '0;
        end else begin
          acc_r_q <= sum_r_d;
          acc_i_q <= sum_i_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_compmac.sv
// tb/tb_compmac.sv - self-checking bench for compmac
module tb_compmac;

  localparam int N     = 8;
  localparam int LEN_W = 8;
  localparam int ACC_W = 2*N+1+LEN_W;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_valid = 1'b0;
  logic signed [N-1:0]     a_r = '0, a_i = '0, b_r = '0, b_i = '0;
  logic                    conj = 1'b0;
  logic [LEN_W-1:0]        len = '0;
  logic                    out_valid;
  logic signed [ACC_W-1:0] c_r, c_i;

  compmac #(.N(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
    .conj(conj), .len(len),
    .out_valid(out_valid), .c_r(c_r), .c_i(c_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;

  // Reference model: frame bookkeeping with plain integers
  typedef struct { int e; longint re; longint im; } pulse_t;
  pulse_t   exp_q[$];
  int       m_cnt = 0;
  int       m_len = 0;
  longint   m_acc_re = 0, m_acc_im = 0;
  longint   hold_re = 0, hold_im = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic model_sample(input bit cj, input int ln, input int ar, input int ai,
                              input int br, input int bi);
    longint re, im;
    int eff;
    if (!cj) begin
      re = ar*br - ai*bi;
      im = ar*bi + ai*br;
    end else begin
      re = ar*br + ai*bi;
      im = ai*br - ar*bi;
    end
    if (m_cnt == 0) m_len = ln;
    eff = (m_len == 0) ? 1 : m_len;
    m_acc_re += re;
    m_acc_im += im;
    m_cnt++;
    if (m_cnt >= eff) begin
      exp_q.push_back('{edge_n + 2, m_acc_re, m_acc_im});
      m_acc_re = 0;
      m_acc_im = 0;
      m_cnt = 0;
    end
  endtask

  task automatic check_outputs();
    longint exp_v;
    exp_v = 0;
    if (exp_q.size() > 0 && exp_q[0].e == edge_n) begin
      exp_v   = 1;
      hold_re = exp_q[0].re;
      hold_im = exp_q[0].im;
      void'(exp_q.pop_front());
    end
    chk("out_valid", longint'(out_valid), exp_v);
    chk("c_r", longint'(c_r), hold_re);
    chk("c_i", longint'(c_i), hold_im);
  endtask

  task automatic step(input bit v, input bit cj, input int ln, input int ar, input int ai,
                      input int br, input int bi);
    in_valid = v;
    conj     = cj;
    len      = LEN_W'(ln);
    a_r      = N'(ar);
    a_i      = N'(ai);
    b_r      = N'(br);
    b_i      = N'(bi);
    @(posedge clk);
    edge_n++;
    if (!reset && v) model_sample(cj, ln, ar, ai, br, bi);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset raised between edges; outputs must clear at once
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_c_r", longint'(c_r), 0);
    chk("rst_c_i", longint'(c_i), 0);
    exp_q.delete();
    m_cnt = 0; m_acc_re = 0; m_acc_im = 0;
    hold_re = 0; hold_im = 0;
    in_valid = 1'b0;
    @(posedge clk);
    edge_n++;
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    int     ln;
    int     nrep;
    bit     cj;
    int     ar, ai, br, bi;
    longint exp_re, exp_im;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1,   1,   1'b0,    1,    2,    3,    4,      -5,     10};
    tbl[1] = '{1,   1,   1'b1,    1,    2,    3,    4,      11,      2};
    tbl[2] = '{1,   1,   1'b1, -128, -128, -128, -128,   32768,      0};
    tbl[3] = '{1,   1,   1'b0, -128, -128, -128, -128,       0,  32768};
    tbl[4] = '{255, 255, 1'b0, -128, -128, -128,  127, 8323200,  32640};
    tbl[5] = '{0,   2,   1'b0,    2,    3,    4,    5,      -7,     22};
    tbl[6] = '{4,   4,   1'b1,    5,   -3,    2,    7,     -44,   -164};

    #1;
    chk("init_out_valid", longint'(out_valid), 0);
    chk("init_c_r", longint'(c_r), 0);
    chk("init_c_i", longint'(c_i), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    for (int t = 0; t < 7; t++) begin
      for (int r = 0; r < tbl[t].nrep; r++)
        step(1'b1, tbl[t].cj, tbl[t].ln, tbl[t].ar, tbl[t].ai, tbl[t].br, tbl[t].bi);
      idle(3);
      chk($sformatf("tbl%0d_c_r", t), longint'(c_r), tbl[t].exp_re);
      chk($sformatf("tbl%0d_c_i", t), longint'(c_i), tbl[t].exp_im);
    end
    idle(6);
    chk("hold_c_r", longint'(c_r), 8323200 - 8323200 + tbl[6].exp_re);

    // len=3 with a bubble between the 2nd and 3rd samples
    step(1'b1, 1'b0, 3, 1, 2, 3, 4);
    step(1'b1, 1'b0, 3, 2, 3, 4, 5);
    step(1'b0, 1'b0, 3, 0, 0, 0, 0);
    step(1'b1, 1'b0, 3, 3, 4, 5, 6);
    step(1'b0, 1'b0, 3, 0, 0, 0, 0);
    chk("bubble_early", longint'(out_valid), 0);
    step(1'b0, 1'b0, 3, 0, 0, 0, 0);
    chk("bubble_pulse", longint'(out_valid), 1);
    chk("bubble_c_r", longint'(c_r), -21);
    chk("bubble_c_i", longint'(c_i), 70);
    idle(2);

    // len changes mid-frame are ignored; frames run back to back
    step(1'b1, 1'b0, 2, 1, 1, 1, 1);
    step(1'b1, 1'b0, 5, 2, 0, 3, 0);
    step(1'b1, 1'b1, 2, -4, 7, 6, -2);
    step(1'b1, 1'b0, 5, 9, -9, 1, 1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 5 - k, k, 1, 2, -k);
    idle(4);

    // Reset after 2 of 3 samples, then a fresh single-sample frame
    step(1'b1, 1'b0, 3, 7, 7, 7, 7);
    step(1'b1, 1'b0, 3, 7, 7, 7, 7);
    do_reset();
    idle(3);
    step(1'b1, 1'b0, 1, 1, 2, 3, 4);
    idle(3);
    chk("post_rst_c_r", longint'(c_r), -5);
    chk("post_rst_c_i", longint'(c_i), 10);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      if (k == 300) do_reset();
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 6),
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    end
    idle(4);
    chk("pending_pulses", longint'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
